// File: rtl/mc_main_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mc_main_ctrl_if                                                  |
// | Brief   : Control bundle between the multi-cycle MIPS main controller and  |
// |           the datapath/memory: opcode and memory handshake in, datapath     |
// |           select/enable signals, debug state and status out.              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface mc_main_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOP;
  logic [1:0]       PCSource;
  logic [3:0]       State;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_cnt;

  // Datapath / stimulus side: supplies opcode and memory handshake
  modport master (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource,
           State, illegal_op, instr_cnt
  );

  // Controller side
  modport slave (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource,
           State, illegal_op, instr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mc_main_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mc_main_ctrl                                                     |
// | Brief   : Main control FSM of the multi-cycle MIPS datapath. Sequences     |
// |           fetch/decode/execute/memory/write-back, drives ALUOP to the ALU  |
// |           control decoder, counts retired instructions and flags illegal   |
// |           opcodes (sticky).                                                |
// | Config  : define CTRL_ADDI_EN to add the ADDI path (states AIEX/AIWB).     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mc_main_ctrl #(
  parameter int         CNT_W    = 32,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input wire logic      clk,
  input wire logic      rst_n,
  mc_main_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_EXE  = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_JMP  = 4'd9,
    S_AIEX = 4'd10,
    S_AIWB = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_cnt;

  logic             w_retire;
  logic             w_set_illegal;
  logic             w_pc_write;
  logic             w_pc_write_cond;
  logic             w_iord;
  logic             w_mem_read;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_mem_to_reg;
  logic             w_reg_dst;
  logic             w_reg_write;
  logic             w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic [1:0]       w_alu_op;
  logic [1:0]       w_pc_source;

  // State register; reset aborts any instruction and restarts at fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_next;
  end

  // Next-state, retire/illegal events and control decode from the current state
  always_comb begin
    w_next          = S_IF;
    w_retire        = 1'b0;
    w_set_illegal   = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    case (r_state)
      S_IF: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
        w_next      = bus.mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        // Branch target is precomputed here while the opcode is decoded
        w_alu_src_b = 2'b11;
        w_alu_op    = 2'b01;
        case (bus.Op)
          OP_LW, OP_SW: w_next = S_MADR;
          OP_RTYPE:     w_next = S_EXE;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      w_next = S_AIEX;
`else
          OP_ADDI: begin
            w_next        = S_IF;
            w_set_illegal = 1'b1;
          end
`endif
          default: begin
            w_next        = S_IF;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 2'b01;
        w_next      = (bus.Op == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        w_next     = bus.mem_ready ? S_MWB : S_MRD;
      end
      S_MWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_IF;
      end
      S_MWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_retire    = bus.mem_ready;
        w_next      = bus.mem_ready ? S_IF : S_MWR;
      end
      S_EXE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b00;
        w_next      = S_RWB;
      end
      S_RWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_IF;
      end
      S_BEQ: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b10;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_retire        = 1'b1;
        w_next          = S_IF;
      end
      S_JMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
        w_retire    = 1'b1;
        w_next      = S_IF;
      end
`ifdef CTRL_ADDI_EN
      S_AIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 2'b01;
        w_next      = S_AIWB;
      end
      S_AIWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_IF;
      end
`endif
      // Unused encodings fall back to fetch silently
      default: w_next = S_IF;
    endcase
  end

  // Sticky illegal-opcode flag and wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal   <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_retire)      r_instr_cnt <= r_instr_cnt + c_cnt_one;
    end
  end

  assign bus.PCWrite     = w_pc_write;
  assign bus.PCWriteCond = w_pc_write_cond;
  assign bus.IorD        = w_iord;
  assign bus.MemRead     = w_mem_read;
  assign bus.MemWrite    = w_mem_write;
  assign bus.IRWrite     = w_ir_write;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.RegDst      = w_reg_dst;
  assign bus.RegWrite    = w_reg_write;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.ALUOP       = w_alu_op;
  assign bus.PCSource    = w_pc_source;
  assign bus.State       = r_state;
  assign bus.illegal_op  = r_illegal;
  assign bus.instr_cnt   = r_instr_cnt;

endmodule
`default_nettype wire

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU control decoder.
- Decodes the 6-bit opcode from the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back cycles.
- Drives the 2-bit ALUOP consumed by the ALU control decoder: 00 = decode Func, 01 = add, 10 = sub.
- Handshakes with a unified instruction/data memory through mem_ready, counts retired instructions, and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load-word opcode.
- OP_SW, 6'b101011, store-word opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_J, 6'b000010, jump opcode.
- OP_ADDI, 6'b001000, add-immediate opcode (used only when CTRL_ADDI_EN is defined).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Op  in  6  opcode, IR[31:26]; valid from the ID state onward.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOP  out  2  to the ALU control decoder.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- State  out  4  current state, for debug.
- illegal_op  out  1  sticky illegal-opcode flag.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- State register, 4 bits. Encoding: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, EXE=6, RWB=7, BEQ=8, JMP=9, AIEX=10, AIWB=11.
- Reset (asynchronous, rst_n=0): State=IF, illegal_op=0, instr_cnt=0.
- Control outputs are decoded combinationally from State (plus mem_ready where listed). During reset they therefore take the IF values. Any control signal not listed for a state is 0.
- IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=01, PCSource=00.
  - IRWrite=mem_ready and PCWrite=mem_ready.
  - Stays in IF while mem_ready=0; goes to ID when mem_ready=1.
- ID: ALUSrcA=0, ALUSrcB=11, ALUOP=01 (branch target precompute).
  - Next state by Op: LW/SW -> MADR, RTYPE -> EXE, BEQ -> BEQ, J -> JMP.
  - Any other Op -> IF; illegal_op is set on that edge; instr_cnt is unchanged.
- MADR: ALUSrcA=1, ALUSrcB=10, ALUOP=01. Goes to MRD if Op=LW, otherwise MWR.
- MRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MWB.
- MWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state IF.
- MWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to IF.
- EXE: ALUSrcA=1, ALUSrcB=00, ALUOP=00. Next state RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state IF.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOP=10, PCWriteCond=1, PCSource=01. Next state IF.
- JMP: PCWrite=1, PCSource=10. Next state IF.
- Latency per instruction with mem_ready always 1:
  - lw: 5 cycles.
  - sw, R-type: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle of mem_ready=0 in IF, MRD or MWR adds one cycle.
- Retire and counting:
  - An instruction retires on the edge that returns to IF from MWB, MWR (with mem_ready=1), RWB, BEQ, JMP or AIWB.
  - instr_cnt increments by 1 at retire and wraps from all-ones to 0.
  - An illegal opcode never counts.
- illegal_op stays 1 until reset.
- Op may change outside ID; the FSM samples it only in ID and MADR.
- Reset mid-instruction aborts immediately. No partial write is issued after rst_n deasserts, because the FSM restarts in IF.
- Unused encodings 12-15 go to IF on the next edge, with no retire and no flag.

Optional Feature:
- Macro: CTRL_ADDI_EN.
- Defined:
  - ID with Op=OP_ADDI goes to AIEX.
  - AIEX: ALUSrcA=1, ALUSrcB=10, ALUOP=01. Next state AIWB.
  - AIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state IF, retiring the instruction.
- Undefined: OP_ADDI is illegal (sets illegal_op, returns to IF); states 10/11 are unreachable and treated as unused encodings.

Test Plan:
- Reset, then release with mem_ready=1 and Op=000000 -> States 0,1,6,7,0; ALUOP=00 in EXE; RegWrite=1 and RegDst=1 in RWB; instr_cnt=1.
- Op=100011 with mem_ready low for 2 cycles in MRD -> MRD held 3 cycles; then MWB with MemtoReg=1 and RegWrite=1; total 7 cycles; instr_cnt increments by 1.
- Op=000100 -> BEQ state: ALUOP=10, PCWriteCond=1, PCSource=01; back to IF after 3 cycles.
- Op=111111 -> IF, ID, IF; illegal_op=1 and stays 1; instr_cnt unchanged; next valid instruction executes normally.
- Assert rst_n=0 during MWR -> State=0 and MemWrite=0 asynchronously; instr_cnt=0.
- With CTRL_ADDI_EN, Op=001000 -> States 0,1,10,11,0; ALUSrcB=10 in AIEX; RegDst=0 in AIWB. Without the macro -> illegal_op=1.
